fork_join_scheduler: RTL and testbench

//   Hardware launcher for parallel timed jobs, modelled on fork/join semantics.
//   - One start command launches any subset of NUM_CH channels; each channel runs its own duration countdown.
//   - join_done then fires in JOIN_ALL, JOIN_ANY or JOIN_NONE fashion.
//   - Acts as the sequencing core behind the team's parallel-task stimulus engines.

---
 rtl/fork_join_scheduler.sv | 135 +++++++++++++
 tb/tb_fork_join_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fork_join_scheduler.sv
// ============================================================================
// Module   : fork_join_scheduler
// Purpose  : Launches timed jobs on a subset of parallel channels and reports
//            the join in ALL / ANY / NONE fashion. Optional kill: FJS_KILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fork_join_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic [NUM_CH*CNT_W-1:0] dur,
    input  logic [1:0]              join_mode,
`ifdef FJS_KILL_EN
    input  logic                    kill,
`endif
    output logic                    ready,
    output logic [NUM_CH-1:0]       ch_active,
    output logic [NUM_CH-1:0]       ch_done,
    output logic                    join_done,
    output logic                    collide
);

    localparam logic [0:0] c_IDLE      = 1'b0;
    localparam logic [0:0] c_RUN       = 1'b1;
    localparam logic [1:0] c_JOIN_ANY  = 2'd1;
    localparam logic [1:0] c_JOIN_NONE = 2'd2;

    logic [0:0]        r_state;
    logic [1:0]        r_mode;
    logic [NUM_CH-1:0] r_join_set;
    logic [NUM_CH-1:0] r_active;
    logic [NUM_CH-1:0] r_done;
    logic              r_join;
    logic              r_collide;
    logic [CNT_W-1:0]  r_cnt [NUM_CH];

    logic              w_kill;
    logic              w_accept;
    logic [NUM_CH-1:0] w_launch;
    logic [NUM_CH-1:0] w_fin;
    logic              w_coll;
    logic              w_join_hit;

`ifdef FJS_KILL_EN
    assign w_kill = kill;
`else
    assign w_kill = 1'b0;
`endif

    assign w_accept = start && (r_state == c_IDLE) && !w_kill;
    assign w_launch = w_accept ? (ch_mask & ~r_active) : '0;
    assign w_coll   = w_accept && (|(ch_mask & r_active));

    // Any mode other than ANY/NONE (including the reserved code) joins on ALL.
    always_comb begin
        w_join_hit = 1'b0;
        if (r_state == c_RUN) begin
            if ((r_mode == c_JOIN_NONE) || (r_join_set == '0))
                w_join_hit = 1'b1;
            else if (r_mode == c_JOIN_ANY)
                w_join_hit = |(r_join_set & w_fin);
            else
                w_join_hit = ((r_join_set & ~w_fin) == '0);
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] w_dur;
            assign w_dur    = dur[i*CNT_W +: CNT_W];
            assign w_fin[i] = r_active[i] && (r_cnt[i] == CNT_W'(1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt[i] <= '0;
                end else if (w_kill) begin
                    r_cnt[i] <= '0;
                end else if (w_launch[i]) begin
                    r_cnt[i] <= (w_dur == '0) ? CNT_W'(1) : w_dur;
                end else if (r_active[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_mode     <= '0;
            r_join_set <= '0;
            r_active   <= '0;
            r_done     <= '0;
            r_join     <= 1'b0;
            r_collide  <= 1'b0;
        end else if (w_kill) begin
            r_state    <= c_IDLE;
            r_join_set <= '0;
            r_active   <= '0;
            r_done     <= '0;
            r_join     <= 1'b0;
            r_collide  <= 1'b0;
        end else begin
            r_active  <= (r_active & ~w_fin) | w_launch;
            r_done    <= w_fin;
            r_join    <= w_join_hit;
            r_collide <= w_coll;
            if (w_accept) begin
                r_state    <= c_RUN;
                r_mode     <= join_mode;
                r_join_set <= ch_mask & ~r_active;
            end else if (w_join_hit) begin
                r_state    <= c_IDLE;
                r_join_set <= '0;
            end else begin
                r_join_set <= r_join_set & ~w_fin;
            end
        end
    end

    assign ready     = (r_state == c_IDLE);
    assign ch_active = r_active;
    assign ch_done   = r_done;
    assign join_done = r_join;
    assign collide   = r_collide;

endmodule

`default_nettype wire

// File: tb/tb_fork_join_scheduler.sv
// ============================================================================
// Module   : tb_fork_join_scheduler
// Purpose  : Self-checking bench for fork_join_scheduler (NUM_CH=4, CNT_W=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fork_join_scheduler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [NUM_CH-1:0]       ch_mask;
    logic [NUM_CH*CNT_W-1:0] dur;
    logic [1:0]              join_mode;
    logic                    kill;
    logic                    ready;
    logic [NUM_CH-1:0]       ch_active;
    logic [NUM_CH-1:0]       ch_done;
    logic                    join_done;
    logic                    collide;

    always #5 clk = ~clk;

    fork_join_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ch_mask   (ch_mask),
        .dur       (dur),
        .join_mode (join_mode),
`ifdef FJS_KILL_EN
        .kill      (kill),
`endif
        .ready     (ready),
        .ch_active (ch_active),
        .ch_done   (ch_done),
        .join_done (join_done),
        .collide   (collide)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         cyc;
        logic [3:0] done;
        logic       jn;
    } ev_t;
    ev_t sbq[$];

    typedef struct {
        logic [1:0]       mode;
        logic [3:0]       mask;
        logic [31:0]      dur;
        int               jn;
        logic [3:0][7:0]  dn;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the pulses a launch at cycle t0 should produce.
    task automatic sb_push(input int t0, input logic [3:0][7:0] dn, input int jn);
        for (int c = 1; c <= 40; c++) begin
            logic [3:0] d;
            logic       j;
            d = '0;
            for (int i = 0; i < 4; i++) if (int'(dn[i]) == c) d[i] = 1'b1;
            j = (jn == c);
            if (d != '0 || j) sbq.push_back('{t0 + c, d, j});
        end
    endtask

    task automatic sb_step(input int k);
        logic [3:0] ed;
        logic       ej;
        ed = '0;
        ej = 1'b0;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].cyc == k) begin
                ed |= sbq[i].done;
                ej |= sbq[i].jn;
                sbq.delete(i);
            end
        end
        chk($sformatf("ch_done@%0d", k), int'(ch_done), int'(ed));
        chk($sformatf("join_done@%0d", k), int'(join_done), int'(ej));
    endtask

    task automatic do_start(input logic [1:0] m, input logic [3:0] mk, input logic [31:0] d);
        @(negedge clk);
        start     = 1'b1;
        join_mode = m;
        ch_mask   = mk;
        dur       = d;
        @(posedge clk);
        #1;
        start   = 1'b0;
        ch_mask = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((ch_active != '0 || !ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_wait_timeout", int'(n < 100), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        ch_mask   = '0;
        dur       = '0;
        join_mode = '0;
        kill      = 1'b0;

        vecs[0] = '{2'd2, 4'b0011, {8'd0, 8'd0, 8'd10, 8'd20}, 1, {8'd0, 8'd0, 8'd10, 8'd20}};
        vecs[1] = '{2'd0, 4'b0111, {8'd0, 8'd9, 8'd3, 8'd5},   9, {8'd0, 8'd9, 8'd3, 8'd5}};
        vecs[2] = '{2'd1, 4'b0011, {8'd0, 8'd0, 8'd4, 8'd4},   4, {8'd0, 8'd0, 8'd4, 8'd4}};
        vecs[3] = '{2'd1, 4'b0011, {8'd0, 8'd0, 8'd7, 8'd4},   4, {8'd0, 8'd0, 8'd7, 8'd4}};
        vecs[4] = '{2'd0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd0},   1, {8'd0, 8'd0, 8'd0, 8'd1}};
        vecs[5] = '{2'd0, 4'b0000, {8'd5, 8'd5, 8'd5, 8'd5},   1, {8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[6] = '{2'd3, 4'b1000, {8'd2, 8'd0, 8'd0, 8'd0},   2, {8'd2, 8'd0, 8'd0, 8'd0}};
        vecs[7] = '{2'd1, 4'b1100, {8'd3, 8'd6, 8'd0, 8'd0},   3, {8'd3, 8'd6, 8'd0, 8'd0}};
        vecs[8] = '{2'd2, 4'b0000, {8'd4, 8'd4, 8'd4, 8'd4},   1, {8'd0, 8'd0, 8'd0, 8'd0}};
        vecs[9] = '{2'd0, 4'b1111, {8'd1, 8'd2, 8'd3, 8'd4},   4, {8'd1, 8'd2, 8'd3, 8'd4}};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_ch_active", int'(ch_active), 0);
        chk("rst_ch_done", int'(ch_done), 0);
        chk("rst_join_done", int'(join_done), 0);
        chk("rst_collide", int'(collide), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven launches, each from a fully idle scheduler.
        for (int v = 0; v < 10; v++) begin
            wait_idle();
            sb_push(0, vecs[v].dn, vecs[v].jn);
            do_start(vecs[v].mode, vecs[v].mask, vecs[v].dur);
            chk($sformatf("v%0d_ready_E0", v), int'(ready), 0);
            for (int k = 1; k <= 24; k++) begin
                logic [3:0] ea;
                @(posedge clk);
                #1;
                sb_step(k);
                for (int i = 0; i < 4; i++)
                    ea[i] = vecs[v].mask[i] && (k < int'(vecs[v].dn[i]));
                chk($sformatf("v%0d_ready@%0d", v, k), int'(ready), int'(k >= vecs[v].jn));
                chk($sformatf("v%0d_active@%0d", v, k), int'(ch_active), int'(ea));
                chk($sformatf("v%0d_collide@%0d", v, k), int'(collide), 0);
            end
            chk($sformatf("v%0d_sb_empty", v), sbq.size(), 0);
            sbq.delete();
        end

        // Collision: ch0 left running by JOIN_NONE, then JOIN_ALL on ch0+ch1 at E2.
        wait_idle();
        sb_push(0, {8'd0, 8'd0, 8'd0, 8'd10}, 1);
        do_start(2'd2, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd10});
        for (int k = 1; k <= 14; k++) begin
            if (k == 2) begin
                start     = 1'b1;
                join_mode = 2'd0;
                ch_mask   = 4'b0011;
                dur       = {8'd0, 8'd0, 8'd3, 8'd2};
                sb_push(2, {8'd0, 8'd0, 8'd3, 8'd0}, 3);
            end
            @(posedge clk);
            #1;
            start   = 1'b0;
            ch_mask = '0;
            sb_step(k);
            chk($sformatf("coll_collide@%0d", k), int'(collide), int'(k == 2));
            chk($sformatf("coll_ch0_active@%0d", k), int'(ch_active[0]), int'(k < 10));
            chk($sformatf("coll_ready@%0d", k), int'(ready), int'(k == 1 || k >= 5));
        end
        chk("coll_sb_empty", sbq.size(), 0);
        sbq.delete();

        // Asynchronous reset in the middle of a dur=8 job.
        wait_idle();
        do_start(2'd0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd8});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", int'(ready), 1);
        chk("mrst_ch_active", int'(ch_active), 0);
        chk("mrst_ch_done", int'(ch_done), 0);
        chk("mrst_join_done", int'(join_done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            sb_step(k);
            chk($sformatf("mrst_active@%0d", k), int'(ch_active), 0);
        end

`ifdef FJS_KILL_EN
        // Kill at E4 of a JOIN_ALL dur=10 job: nothing completes afterwards.
        wait_idle();
        do_start(2'd0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd10});
        for (int k = 1; k <= 14; k++) begin
            if (k == 4) kill = 1'b1;
            @(posedge clk);
            #1;
            kill = 1'b0;
            sb_step(k);
            if (k >= 4) begin
                chk($sformatf("kill_active@%0d", k), int'(ch_active), 0);
                chk($sformatf("kill_ready@%0d", k), int'(ready), 1);
            end
        end
        // kill and start on the same edge: the start is dropped.
        @(negedge clk);
        kill      = 1'b1;
        start     = 1'b1;
        join_mode = 2'd0;
        ch_mask   = 4'b0001;
        dur       = {8'd0, 8'd0, 8'd0, 8'd5};
        @(posedge clk);
        #1;
        kill    = 1'b0;
        start   = 1'b0;
        ch_mask = '0;
        chk("killstart_ready", int'(ready), 1);
        chk("killstart_active", int'(ch_active), 0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            sb_step(k);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
